cordic_angle_reducer: RTL

Upstream range-reduction stage for the sine/cosine CORDIC core. It accepts a signed fixed-point angle and folds it into the first quadrant [0, π/2). It produces the 2-bit `shift_region_flag` and a result-sign bit that the CORDIC FSM and the output sign stage consume. Reduction is iterative: one π/2 subtraction per clock, under a begin/ready/ack handshake identical in style to the CORDIC FSM's.

---
 rtl/cordic_angle_reducer_if.sv | 36 +++
 rtl/cordic_angle_reducer.sv | 109 ++++++++++
 2 files changed

// File: rtl/cordic_angle_reducer_if.sv
// Handshake and data bundle between the angle reducer and its requester.
// The requester drives the master side and the reducer drives the slave side.
interface cordic_angle_reducer_if #(
    parameter int W = 32
);
    logic         beg_angle_red;
    logic         ack_angle_red;
    logic         operation;
    logic [W-1:0] angle_in;
    logic [W-1:0] angle_out;
    logic [1:0]   shift_region_flag;
    logic         sign_result;
    logic         ready_angle_red;

    modport master (
        output beg_angle_red,
        output ack_angle_red,
        output operation,
        output angle_in,
        input  angle_out,
        input  shift_region_flag,
        input  sign_result,
        input  ready_angle_red
    );

    modport slave (
        input  beg_angle_red,
        input  ack_angle_red,
        input  operation,
        input  angle_in,
        output angle_out,
        output shift_region_flag,
        output sign_result,
        output ready_angle_red
    );
endinterface

// File: rtl/cordic_angle_reducer.sv
// Iterative range reduction of a Q3.(W-3) angle into [0, pi/2) for the CORDIC core.
// Each clock removes one pi/2; the number removed picks the quadrant code and result sign.
module cordic_angle_reducer #(
    parameter int           W    = 32,
    parameter logic [W-1:0] PI_2 = 32'h3243F6A9
) (
    input logic                   clk,
    input logic                   reset,
    cordic_angle_reducer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WRAP,
        REDUCE,
        DONE
    } state_t;

    localparam logic signed [W:0] C_PI_2   = {1'b0, PI_2};
    localparam logic signed [W:0] C_TWO_PI = C_PI_2 <<< 2;

    state_t              r_state;
    state_t              w_next_state;
    logic signed [W:0]   r_acc;
    logic [1:0]          r_n;
    logic                r_op;
    logic [W-1:0]        r_angle_out;
    logic [1:0]          r_flag;
    logic                r_sign;
    logic                r_ready;

    logic                w_can_sub;
    logic [1:0]          w_gray;
    logic                w_sign;

    // The n<3 cap keeps the quadrant code meaningful even if rounding leaves acc at 2*pi.
    assign w_can_sub = (r_acc >= C_PI_2) && (r_n != 2'd3);
    assign w_gray    = {r_n[1], r_n[1] ^ r_n[0]};
    assign w_sign    = r_op ? r_n[1] : (r_n[1] ^ r_n[0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.beg_angle_red) w_next_state = WRAP;
            WRAP:    w_next_state = REDUCE;
            REDUCE:  if (!w_can_sub) w_next_state = DONE;
            DONE:    if (bus.ack_angle_red) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_n         <= 2'd0;
            r_op        <= 1'b0;
            r_angle_out <= '0;
            r_flag      <= 2'b00;
            r_sign      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.beg_angle_red) begin
                        r_acc <= {bus.angle_in[W-1], bus.angle_in};
                        r_op  <= bus.operation;
                        r_n   <= 2'd0;
                    end
                end
                WRAP: begin
                    if (r_acc[W]) begin
                        r_acc <= r_acc + C_TWO_PI;
                    end
                end
                REDUCE: begin
                    if (w_can_sub) begin
                        r_acc <= r_acc - C_PI_2;
                        r_n   <= r_n + 2'd1;
                    end else begin
                        r_angle_out <= r_acc[W-1:0];
                        r_flag      <= w_gray;
                        r_sign      <= w_sign;
                        r_ready     <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ack_angle_red) begin
                        r_ready <= 1'b0;
                    end
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign bus.angle_out         = r_angle_out;
    assign bus.shift_region_flag = r_flag;
    assign bus.sign_result       = r_sign;
    assign bus.ready_angle_red   = r_ready;

endmodule
